// File: rtl/wb_pkg.sv
// Shared defaults and grant encoding for the writeback arbiter and its scoreboard.
package wb_pkg;

    localparam int DWIDTH_DEF       = 32;
    localparam int AWIDTH_DEF       = 5;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LD   = 2'd2
    } gnt_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set on load issue and
// cleared on load writeback. Lookups read the registered state only.
import wb_pkg::*;

module wb_scoreboard #(
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              set_valid,
    input  logic [AWIDTH-1:0] set_rd,
    input  logic              clr_valid,
    input  logic [AWIDTH-1:0] clr_rd,
    input  logic [AWIDTH-1:0] chk_rs1,
    input  logic [AWIDTH-1:0] chk_rs2,
    input  logic [AWIDTH-1:0] chk_rd,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              busy_rd
);

    localparam int NREG = 1 << AWIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-cycle reissue stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_valid) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_rs1 = busy_q[chk_rs1];
    assign busy_rs2 = busy_q[chk_rs2];
    assign busy_rd  = busy_q[chk_rd];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks the ALU or a load response each cycle, registers the
// winner onto the register-file write port and forces loads through after starvation.
import wb_pkg::*;

module wb_arbiter #(
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              alu_valid,
    input  logic [AWIDTH-1:0] alu_rd,
    input  logic [DWIDTH-1:0] alu_data,
    output logic              alu_hold,
    input  logic              ld_valid,
    input  logic [AWIDTH-1:0] ld_rd,
    input  logic [DWIDTH-1:0] ld_data,
    output logic              ld_ready,
    input  logic              iss_ld_valid,
    input  logic [AWIDTH-1:0] iss_ld_rd,
    input  logic [AWIDTH-1:0] chk_rs1,
    input  logic [AWIDTH-1:0] chk_rs2,
    input  logic [AWIDTH-1:0] chk_rd,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              busy_rd,
    output logic              wb_we,
    output logic [AWIDTH-1:0] wb_addr_rd,
    output logic [DWIDTH-1:0] wb_data_rd
);

    // Handshake: a load response transfers in any cycle with ld_valid && ld_ready;
    // an ALU result transfers when alu_valid && !alu_hold, otherwise upstream holds it.

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_d;
    logic              ld_force;
    gnt_e              gnt;
    logic [AWIDTH-1:0] gnt_rd;
    logic [DWIDTH-1:0] gnt_data;

    assign ld_force = (starve_cnt == LIMIT) && ld_valid;
    assign ld_ready = !alu_valid || ld_force;
    assign alu_hold = alu_valid && ld_force;

    always_comb begin
        gnt      = GNT_NONE;
        gnt_rd   = alu_rd;
        gnt_data = alu_data;
        if (ld_valid && (!alu_valid || ld_force)) begin
            gnt      = GNT_LD;
            gnt_rd   = ld_rd;
            gnt_data = ld_data;
        end else if (alu_valid) begin
            gnt = GNT_ALU;
        end
    end

    // Counts consecutive cycles a waiting load lost to the ALU.
    always_comb begin
        starve_d = starve_cnt;
        if (!ld_valid || gnt == GNT_LD) begin
            starve_d = '0;
        end else if (alu_valid && !ld_force && starve_cnt != LIMIT) begin
            starve_d = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            starve_cnt <= '0;
            wb_we      <= 1'b0;
            wb_addr_rd <= '0;
            wb_data_rd <= '0;
        end else begin
            starve_cnt <= starve_d;
            wb_we      <= (gnt != GNT_NONE) && (gnt_rd != '0);
            if ((gnt != GNT_NONE) && (gnt_rd != '0)) begin
                wb_addr_rd <= gnt_rd;
                wb_data_rd <= gnt_data;
            end
        end
    end

    wb_scoreboard #(
        .AWIDTH (AWIDTH)
    ) u_scoreboard (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .set_valid (iss_ld_valid),
        .set_rd    (iss_ld_rd),
        .clr_valid (gnt == GNT_LD),
        .clr_rd    (ld_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_rd   (busy_rd)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, checked
// against a behavioural model; writeback expectations flow through a queue.
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;
    localparam int EW    = 1 + AW + DW;

    logic          r_clk;
    logic          r_rst;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_hold;
    logic          ld_valid;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          iss_ld_valid;
    logic [AW-1:0] iss_ld_rd;
    logic [AW-1:0] chk_rs1, chk_rs2, chk_rd;
    logic          busy_rs1, busy_rs2, busy_rd;
    logic          wb_we;
    logic [AW-1:0] wb_addr_rd;
    logic [DW-1:0] wb_data_rd;

    wb_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .r_clk        (r_clk),
        .r_rst        (r_rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_hold     (alu_hold),
        .ld_valid     (ld_valid),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .iss_ld_valid (iss_ld_valid),
        .iss_ld_rd    (iss_ld_rd),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .chk_rd       (chk_rd),
        .busy_rs1     (busy_rs1),
        .busy_rs2     (busy_rs2),
        .busy_rd      (busy_rd),
        .wb_we        (wb_we),
        .wb_addr_rd   (wb_addr_rd),
        .wb_data_rd   (wb_data_rd)
    );

    // clock / reset
    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    // behavioural model: pending set, waiting time of the current load, write port
    bit            m_pending[32];
    int            m_wait;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            prev_alu_taken;
    bit            prev_ld_taken;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pending[i] = 0;
        m_wait = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Called mid-cycle after inputs settle: checks combinational outputs and
    // advances the model across the coming clock edge.
    task automatic model_step();
        bit forced, take_ld, take_alu;
        if (!r_rst) model_reset();
        forced   = ld_valid && (m_wait >= LIMIT);
        take_ld  = ld_valid && (!alu_valid || forced);
        take_alu = alu_valid && !forced;
        chk("ld_ready", ld_ready, !alu_valid || forced);
        chk("alu_hold", alu_hold, alu_valid && forced);
        chk("busy_rs1", busy_rs1, m_pending[chk_rs1]);
        chk("busy_rs2", busy_rs2, m_pending[chk_rs2]);
        chk("busy_rd",  busy_rd,  m_pending[chk_rd]);
        if (r_rst) begin
            m_we = 1'b0;
            if (take_ld && ld_rd != 0) begin
                m_we = 1'b1; m_addr = ld_rd; m_data = ld_data;
            end else if (take_alu && alu_rd != 0) begin
                m_we = 1'b1; m_addr = alu_rd; m_data = alu_data;
            end
            if (!ld_valid || take_ld) m_wait = 0;
            else if (alu_valid) m_wait = m_wait + 1;
            if (take_ld) m_pending[ld_rd] = 0;
            if (iss_ld_valid && iss_ld_rd != 0) m_pending[iss_ld_rd] = 1;
            prev_alu_taken = take_alu;
            prev_ld_taken  = take_ld;
        end else begin
            prev_alu_taken = 1;
            prev_ld_taken  = 1;
        end
        exp_q.push_back({m_we, m_addr, m_data});
    endtask

    // driver
    task automatic tick(input logic rst,
                        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldd,
                        input logic iv, input logic [AW-1:0] ird,
                        input logic [AW-1:0] c1, input logic [AW-1:0] c2, input logic [AW-1:0] cd);
        @(negedge r_clk);
        #1;
        r_rst = rst;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ldd;
        iss_ld_valid = iv; iss_ld_rd = ird;
        chk_rs1 = c1; chk_rs2 = c2; chk_rd = cd;
        #1;
        model_step();
    endtask

    task automatic idle(input logic rst, input logic [AW-1:0] c1);
        tick(rst, 0, 0, 0, 0, 0, 0, 0, 0, c1, 0, 0);
    endtask

    // scoreboard monitor: one expected write-port state per cycle
    always @(negedge r_clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_port", {wb_we, wb_addr_rd, wb_data_rd}, e);
        end
    end

    initial begin
        logic          av, lv, iv;
        logic [AW-1:0] ard, lrd, ird;
        logic [DW-1:0] ad, ldd;

        r_rst = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        iss_ld_valid = 0; iss_ld_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        prev_alu_taken = 1; prev_ld_taken = 1;
        model_reset();

        idle(0, 0);
        idle(0, 0);
        chk("reset_we", wb_we, 0);
        chk("reset_data", wb_data_rd, 0);

        // ALU write, one cycle latency
        tick(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_ld_ready_low", ld_ready, 0);
        idle(1, 0);

        // issued load marks r7 busy until its response is written
        tick(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
        idle(1, 7);
        chk("busy_r7_set", busy_rs1, 1);
        tick(1, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0, 0);
        idle(1, 7);
        chk("busy_r7_clr", busy_rs1, 0);
        chk("ld_write_same_cycle", {wb_we, wb_addr_rd, wb_data_rd}, {1'b1, 5'd7, 32'h1234});

        // starvation: continuous ALU, load forced through on the fifth cycle
        for (int i = 0; i < 7; i++) begin
            tick(1, 1, 6, 32'hA000 + ((i == 5) ? 4 : i), (i <= 4), 9, 32'h55, 0, 0, 0, 0, 0);
            chk("starve_hold", alu_hold, (i == 4));
            chk("starve_ready", ld_ready, (i == 4));
        end
        idle(1, 0);

        // writes to r0 are dropped; issuing to r0 marks nothing
        tick(1, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 0, 32'hBEEF, 1, 0, 0, 0, 0);
        chk("r0_we", wb_we, 0);
        idle(1, 0);
        chk("r0_we_ld", wb_we, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_busy", busy_rd, 0);

        // same-cycle reissue and grant of r3 keeps it pending
        tick(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 3, 32'h33, 1, 3, 0, 3, 0);
        idle(1, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("reissue_busy", busy_rs2, 1);

        // reset mid-stream with r3 pending and the load waiting two cycles
        tick(1, 1, 4, 32'h44, 1, 10, 32'hAA, 0, 0, 3, 0, 0);
        tick(1, 1, 4, 32'h45, 1, 10, 32'hAA, 0, 0, 3, 0, 0);
        idle(0, 3);
        chk("rst_busy", busy_rs1, 0);
        chk("rst_we", wb_we, 0);
        tick(1, 0, 0, 0, 1, 3, 32'h77, 0, 0, 3, 0, 0);
        chk("post_rst_ready", ld_ready, 1);
        chk("post_rst_hold", alu_hold, 0);
        idle(1, 0);
        chk("post_rst_write", {wb_we, wb_addr_rd, wb_data_rd}, {1'b1, 5'd3, 32'h77});

        // random traffic; upstream holds un-accepted requests
        for (int n = 0; n < 600; n++) begin
            if (alu_valid && !prev_alu_taken) begin
                av = alu_valid; ard = alu_rd; ad = alu_data;
            end else begin
                av  = ($urandom_range(0, 3) != 0);
                ard = AW'($urandom_range(0, 7));
                ad  = $urandom;
            end
            if (ld_valid && !prev_ld_taken) begin
                lv = ld_valid; lrd = ld_rd; ldd = ld_data;
            end else begin
                lv  = ($urandom_range(0, 1) != 0);
                lrd = AW'($urandom_range(0, 7));
                ldd = $urandom;
            end
            iv  = ($urandom_range(0, 2) == 0);
            ird = AW'($urandom_range(0, 7));
            tick(($urandom_range(0, 149) != 0), av, ard, ad, lv, lrd, ldd, iv, ird,
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        idle(1, 0);
        @(negedge r_clk);
        #3;
        chk("queue_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
